// File: rtl/tdc_ctrl.sv
// Measurement sequencer for a carry-chain TDC fine delay line.
// It arms the line, counts coarse cycles, captures the hit, hands off the result and then holds a dead time.
module tdc_ctrl #(
  parameter int NUM      = 12,
  parameter int COARSE_W = 16,
  parameter int FINE_W   = 4,
  parameter int DEAD_CYC = 4
) (
  input  logic                clk,
  input  logic                iRstN,
  input  logic                iArm,
  input  logic                iAbort,
  input  logic [NUM-1:0]      iFF,
  output logic                oFineRst,
  output logic                oBusy,
  output logic                oValid,
  input  logic                iReady,
  output logic [COARSE_W-1:0] oCoarse,
  output logic [FINE_W-1:0]   oFine,
  output logic                oOverflow,
  output logic                oBubble
);

  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DW-1:0]       DEAD_LAST  = DW'(DEAD_CYC - 1);
  localparam logic [COARSE_W-1:0] COARSE_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, RESULT, DEAD} stateT;

  stateT               state, nextState;
  logic [COARSE_W-1:0] counter;
  logic [DW-1:0]       deadCnt;
  logic [FINE_W-1:0]   popCount;
  logic                bubble;
  logic                saturated;

  assign saturated = (counter == COARSE_MAX);

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) state <= IDLE;
    else        state <= nextState;
  end

  // Abort has priority over a hit, and a hit has priority over saturation.
  always_comb begin
    nextState = state;
    oFineRst  = (state != ARMED);
    oBusy     = (state != IDLE);
    oValid    = (state == RESULT);
    case (state)
      IDLE:    if (iArm) nextState = ARMED;
      ARMED: begin
        if (iAbort)                nextState = DEAD;
        else if (iFF[0] || saturated) nextState = RESULT;
      end
      RESULT:  if (iReady) nextState = DEAD;
      DEAD:    if (deadCnt == DEAD_LAST) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Fine code is the ones-count of the taps; a bubble is any 0 -> 1 step going up the chain.
  always_comb begin
    popCount = '0;
    bubble   = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      popCount = popCount + FINE_W'(iFF[i]);
    end
    for (int i = 1; i < NUM; i++) begin
      bubble = bubble | (iFF[i] & ~iFF[i-1]);
    end
  end

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      counter <= '0;
      deadCnt <= '0;
    end else begin
      counter <= (state == ARMED) ? counter + 1'b1 : '0;
      deadCnt <= (state == DEAD) ? deadCnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      oCoarse   <= '0;
      oFine     <= '0;
      oOverflow <= 1'b0;
      oBubble   <= 1'b0;
    end else if (state == ARMED && !iAbort) begin
      if (iFF[0]) begin
        oCoarse   <= counter;
        oFine     <= popCount;
        oOverflow <= 1'b0;
        oBubble   <= bubble;
      end else if (saturated) begin
        oCoarse   <= COARSE_MAX;
        oFine     <= '0;
        oOverflow <= 1'b1;
        oBubble   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdc_ctrl.sv
// Scoreboard bench for tdc_ctrl: stimulus pushes the expected results into a queue.
// A monitor process compares them with the DUT on every cycle where oValid is high.
module tb_tdc_ctrl;

  localparam int NUM  = 12;
  localparam int CW   = 4;
  localparam int FW   = 4;
  localparam int DEAD = 4;
  localparam int RW   = CW + FW + 2;

  logic          clk = 1'b0;
  logic          iRstN = 1'b0;
  logic          iArm = 1'b0;
  logic          iAbort = 1'b0;
  logic [NUM-1:0] iFF = '0;
  logic          iReady = 1'b0;
  logic          oFineRst, oBusy, oValid, oOverflow, oBubble;
  logic [CW-1:0] oCoarse;
  logic [FW-1:0] oFine;

  logic [RW-1:0] expQ[$];
  int errors = 0;
  int checks = 0;

  tdc_ctrl #(.NUM(NUM), .COARSE_W(CW), .FINE_W(FW), .DEAD_CYC(DEAD)) dut (
    .clk(clk), .iRstN(iRstN), .iArm(iArm), .iAbort(iAbort), .iFF(iFF),
    .oFineRst(oFineRst), .oBusy(oBusy), .oValid(oValid), .iReady(iReady),
    .oCoarse(oCoarse), .oFine(oFine), .oOverflow(oOverflow), .oBubble(oBubble)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference result for a hit: coarse = armed cycle index, fine = ones count,
  // bubble = the code differs from the clean thermometer code with the same ones count.
  function automatic logic [RW-1:0] hitResult(input int cyc, input logic [NUM-1:0] code);
    int n;
    logic [NUM-1:0] clean;
    n = $countones(code);
    clean = NUM'((1 << n) - 1);
    return {CW'(cyc), FW'(n), 1'b0, (code != clean)};
  endfunction

  always @(negedge clk) begin
    if (iRstN && oValid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedValid: got result %0h, expected none", {oCoarse, oFine, oOverflow, oBubble});
      end else begin
        checkOutput("result", {oCoarse, oFine, oOverflow, oBubble}, expQ[0]);
        if (iReady) void'(expQ.pop_front());
      end
    end
  end

  // Runs one measurement: arm, armed cycles with the hit on hitCycle (or overflow), handshake, dead time.
  task automatic applyStimulus(input int hitCycle, input logic [NUM-1:0] code, input bit abort, input int readyDelay);
    bit done = 0;
    bit aborted = 0;
    int c = 0;
    int waited = 0;
    int dead = 0;
    iArm = 1'b1;
    tick();
    iArm = 1'b0;
    checkOutput("armFineRst", oFineRst, 0);
    checkOutput("armBusy", oBusy, 1);
    while (!done) begin
      iAbort = 1'b0;
      if (c == hitCycle) begin
        iFF = code | NUM'(1);
        iAbort = abort;
        done = 1;
        if (abort) aborted = 1;
        else expQ.push_back(hitResult(c, code | NUM'(1)));
      end else begin
        iFF = NUM'($urandom) & ~NUM'(1);
        if (c == (1 << CW) - 1) begin
          expQ.push_back({{CW{1'b1}}, FW'(0), 1'b1, 1'b0});
          done = 1;
        end
      end
      tick();
      c++;
    end
    iFF = '0;
    iAbort = 1'b0;
    if (aborted) begin
      checkOutput("abortNoValid", oValid, 0);
    end else begin
      checkOutput("resultValid", oValid, 1);
      while (oValid && waited < 60) begin
        iReady = (waited >= readyDelay);
        checkOutput("resultFineRst", oFineRst, 1);
        tick();
        waited++;
      end
      iReady = 1'b0;
      checkOutput("handshakeTimeout", oValid, 0);
    end
    iArm = 1'b1;
    while (oBusy && dead < 20) begin
      checkOutput("deadFineRst", oFineRst, 1);
      checkOutput("deadValid", oValid, 0);
      dead++;
      tick();
    end
    iArm = 1'b0;
    checkOutput("deadCycles", dead, DEAD);
    checkOutput("idleFineRst", oFineRst, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    checkOutput("rstFineRst", oFineRst, 1);
    checkOutput("rstBusy", oBusy, 0);
    @(negedge clk);
    iRstN = 1'b1;
    repeat (3) tick();
    checkOutput("idleFineRst", oFineRst, 1);
    checkOutput("idleBusy", oBusy, 0);
    checkOutput("idleValid", oValid, 0);
    checkOutput("idleResults", {oCoarse, oFine, oOverflow, oBubble}, 0);

    applyStimulus(5, 12'h007, 0, 0);
    applyStimulus(3, 12'h00D, 0, 10);
    applyStimulus(0, 12'hFFF, 0, 1);
    applyStimulus(99, 12'h000, 0, 0);
    applyStimulus(15, 12'h001, 0, 0);
    applyStimulus(7, 12'h003, 1, 0);

    for (int k = 0; k < 20; k++) begin
      logic [NUM-1:0] code;
      if ($urandom_range(0, 1) == 1) code = NUM'((1 << $urandom_range(1, NUM)) - 1);
      else code = NUM'($urandom) | NUM'(1);
      applyStimulus($urandom_range(0, 18), code, ($urandom_range(0, 5) == 0), $urandom_range(0, 3));
    end

    iArm = 1'b1;
    tick();
    iArm = 1'b0;
    repeat (3) tick();
    checkOutput("preRstArmed", oFineRst, 0);
    iRstN = 1'b0;
    #1;
    checkOutput("midRstFineRst", oFineRst, 1);
    checkOutput("midRstBusy", oBusy, 0);
    checkOutput("midRstResults", {oCoarse, oFine, oOverflow, oBubble}, 0);
    @(negedge clk);
    iRstN = 1'b1;
    tick();
    checkOutput("postRstValid", oValid, 0);
    applyStimulus(2, 12'h01F, 0, 2);

    checkOutput("queueEmpty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdc_ctrl.md
# tdc_ctrl

Measurement sequencer for the carry-chain fine delay line. Holds the line cleared while idle and releases it on an arm request. Counts coarse clock cycles while armed, and detects the hit from the registered thermometer code. Captures coarse count plus fine code (ones-count of the taps), presents the result on a valid/ready handshake, then enforces a dead time with the line cleared before the next arm is accepted.

## Interface
Parameters:
- NUM, 12, number of fine taps (multiple of 4); width of iFF.
- COARSE_W, 16, coarse counter width.
- FINE_W, 4, fine result width; must satisfy 2^FINE_W > NUM.
- DEAD_CYC, 4, cycles the line is held cleared after a measurement (≥1).

Ports:
- clk  in  1  single system clock; all logic rising-edge.
- iRstN  in  1  asynchronous, active-low reset.
- iArm  in  1  arm request; sampled only in IDLE.
- iAbort  in  1  abandon measurement; sampled only in ARMED.
- iFF  in  NUM  registered thermometer code from the fine line (second FF column), bit 0 = first tap.
- oFineRst  out  1  active-high clear to both fine FF columns.
- oBusy  out  1  high in every state except IDLE.
- oValid  out  1  result valid.
- iReady  in  1  consumer accepts result when oValid & iReady.
- oCoarse  out  COARSE_W  coarse cycle count at hit detection.
- oFine  out  FINE_W  number of ones in iFF at hit detection.
- oOverflow  out  1  coarse counter saturated with no hit; qualified by oValid.
- oBubble  out  1  captured code was not a clean thermometer code; qualified by oValid.

## Operation
- States: IDLE, ARMED, RESULT, DEAD.
- Outputs are registered, or decoded from the registered state only; no path from iFF to an output.
- oFineRst is 0 only in ARMED and 1 in all other states, including during reset.
- IDLE: counter held at 0. iArm=1 → ARMED next cycle.
- ARMED: the counter holds 0 on the first ARMED cycle and then increments by 1 each cycle. Priority in each cycle, highest first:
  - iAbort=1 → DEAD. No result is produced.
  - iFF[0]=1 (hit) → capture, then RESULT. Capture registers:
    - oCoarse ← counter.
    - oFine ← popcount(iFF). Range 1..NUM; NUM means the hit crossed the whole chain.
    - oBubble ← 1 if any iFF[i]=1 with iFF[i-1]=0.
    - oOverflow ← 0.
  - counter = 2^COARSE_W−1 and no hit → RESULT with oCoarse=all ones, oFine=0, oOverflow=1, oBubble=0.
- RESULT: oValid=1 and the result outputs are held stable. On oValid & iReady, go to DEAD. Holds indefinitely otherwise; there is no timeout.
- DEAD: stays exactly DEAD_CYC cycles, then IDLE. iArm is ignored here.
- iArm outside IDLE and iAbort outside ARMED have no effect.
- oCoarse, oFine, oOverflow and oBubble keep their last captured values outside RESULT. They are qualified only by oValid.

## Timing
- Reset values (asynchronous assertion; synchronous release on the next clk edge):
  - state=IDLE, counter=0.
  - oFineRst=1, oBusy=0, oValid=0.
  - oCoarse=0, oFine=0, oOverflow=0, oBubble=0.
- Reset mid-measurement aborts with no result and re-clears the line.
- Arm latency: iArm high at edge k → ARMED and oFineRst=0 from edge k+1.
- Hit detection: hit seen on iFF in cycle c (relative to the first ARMED cycle = 0) → oCoarse=c and oValid=1 from the next edge.
- The fine line adds two register stages. The constant 2-cycle offset is removed downstream, not here.
- Minimum measurement period: 1 (IDLE) + armed cycles + 1 (RESULT, with iReady=1) + DEAD_CYC.
- Abort and hit in the same cycle: abort wins.
- Hit on the saturation cycle: the hit wins and oOverflow=0.

## Test plan
- Reset and idle: iRstN low then high, no iArm → oFineRst=1, oBusy=0, oValid=0, all results 0.
- Basic hit, NUM=12: iArm at edge 0; iFF=12'h007 on ARMED cycle 5 → one cycle later oValid=1, oCoarse=5, oFine=3, oBubble=0, oOverflow=0.
- Backpressure and dead time: hold iReady=0 for 10 cycles → outputs stable and oFineRst=1 throughout. Then assert iReady → DEAD for exactly 4 cycles; iArm during DEAD ignored; iArm in IDLE accepted.
- Bubble and full-chain capture:
  - iFF=12'h00D → oFine=3, oBubble=1.
  - iFF=12'hFFF → oFine=12, oBubble=0.
- Overflow: COARSE_W=4, no hit → oValid after 16 armed cycles with oCoarse=4'hF, oFine=0, oOverflow=1.
- Abort and reset corner cases:
  - iAbort coinciding with iFF[0]=1 → no oValid; DEAD then IDLE.
  - iRstN low while ARMED → immediate IDLE with oFineRst=1.
